// File: rtl/tl_phase_monitor_pkg.sv
// Shared types and constants for the traffic-light phase monitor.
//   phase_t      : decoded light phase (PH_ILL = unrecognised light combination)
//   fault_t      : fault codes, lowest value has priority when several fire together
//   LM_* / LP_*  : light patterns, main/sec {red,yellow,green}, pedestrian {red,green}
//   decode_phase : light inputs -> phase_t
//   legal_trans  : allowed phase-to-phase transitions
package tl_pkg;

    typedef enum logic [2:0] {
        PH_AR, PH_MG, PH_MY, PH_SG, PH_SY, PH_PG, PH_ILL
    } phase_t;

    typedef enum logic [2:0] {
        F_NONE, F_ILL_COMBO, F_ILL_TRANS, F_SHORT, F_LONG, F_PED_SPURIOUS, F_PED_MISSED
    } fault_t;

    localparam logic [2:0] LM_RED = 3'b100;
    localparam logic [2:0] LM_YEL = 3'b010;
    localparam logic [2:0] LM_GRN = 3'b001;
    localparam logic [1:0] LP_RED = 2'b10;
    localparam logic [1:0] LP_GRN = 2'b01;

    function automatic phase_t decode_phase(logic [2:0] main_l, logic [2:0] sec_l, logic [1:0] peat_l);
        phase_t p;
        p = PH_ILL;
        if (peat_l == LP_RED) begin
            if      (main_l == LM_GRN && sec_l == LM_RED) p = PH_MG;
            else if (main_l == LM_YEL && sec_l == LM_RED) p = PH_MY;
            else if (main_l == LM_RED && sec_l == LM_GRN) p = PH_SG;
            else if (main_l == LM_RED && sec_l == LM_YEL) p = PH_SY;
            else if (main_l == LM_RED && sec_l == LM_RED) p = PH_AR;
        end else if (peat_l == LP_GRN && main_l == LM_RED && sec_l == LM_RED) begin
            p = PH_PG;
        end
        return p;
    endfunction

    function automatic logic legal_trans(phase_t from_p, phase_t to_p);
        logic ok;
        case (from_p)
            PH_AR:   ok = (to_p == PH_MG);
            PH_MG:   ok = (to_p == PH_MY);
            PH_MY:   ok = (to_p == PH_SG);
            PH_SG:   ok = (to_p == PH_SY);
            PH_SY:   ok = (to_p == PH_MG) || (to_p == PH_PG);
            PH_PG:   ok = (to_p == PH_AR);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tl_phase_monitor_if.sv
// Light bundle between the traffic-light controller and the phase monitor.
//   main_lights  : {red,yellow,green} main signal
//   sec_lights   : {red,yellow,green} secondary signal
//   peat_lights  : {red,green} pedestrian signal
//   led_peatonal : pending pedestrian request
// master = controller side (drives), slave = monitor side (observes).
interface tl_phase_monitor_if;
    logic [2:0] main_lights;
    logic [2:0] sec_lights;
    logic [1:0] peat_lights;
    logic       led_peatonal;

    modport master (output main_lights, output sec_lights, output peat_lights, output led_peatonal);
    modport slave  (input  main_lights, input  sec_lights, input  peat_lights, input  led_peatonal);
endinterface

// File: rtl/tl_phase_monitor_sec_timer.sv
// Seconds timer for the phase monitor.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : clears divider and seconds together (phase change)
//   tick       : divider is at its last count; secs advances on this edge
//   secs       : whole seconds since last clear, saturating at all-ones
module tl_sec_timer #(
    parameter int FPGAFREQ = 50_000_000,
    parameter int SECBITS  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    output logic               tick,
    output logic [SECBITS-1:0] secs
);
    localparam int DIVW = (FPGAFREQ > 1) ? $clog2(FPGAFREQ) : 1;
    localparam logic [DIVW-1:0] DIV_MAX = DIVW'(FPGAFREQ - 1);

    logic [DIVW-1:0] div;

    assign tick = (div == DIV_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div  <= '0;
            secs <= '0;
        end else if (clr) begin
            div  <= '0;
            secs <= '0;
        end else if (tick) begin
            div <= '0;
            if (secs != '1) secs <= secs + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end
endmodule

// File: rtl/tl_phase_monitor.sv
// Receive-side checker for the traffic-light controller outputs.
// Decodes the light phase, checks transition order, phase durations and
// pedestrian service, and latches the first violation as a sticky fault.
//   clk, reset    : clock, asynchronous active-high reset
//   lights        : tl_phase_monitor_if.slave (main/sec/peat lights, led_peatonal)
//   phase         : registered decoded phase
//   sec_in_phase  : whole seconds in the current phase (saturating)
//   fault         : sticky fault flag
//   fault_code    : code of first violation, F_NONE while fault=0
//   ped_cycles    : pedestrian-green entries (saturating at 255)
// Optional: define TL_MON_PEDCNT_EN to build the ped_cycles counter;
// otherwise ped_cycles is tied to zero.
module tl_phase_monitor
    import tl_pkg::*;
#(
    parameter int FPGAFREQ     = 50_000_000,
    parameter int T_GREENMAIN  = 18,
    parameter int T_YELLOWMAIN = 4,
    parameter int T_GREENSEC   = 10,
    parameter int T_YELLOWSEC  = 3,
    parameter int T_GREENPEAT  = 5,
    parameter int T_RED        = 2,
    parameter int T_RESET      = 3,
    parameter int TOL          = 1,
    parameter int SECBITS      = $clog2(T_GREENMAIN + TOL + 2)
) (
    input  logic               clk,
    input  logic               reset,
    tl_phase_monitor_if.slave  lights,
    output phase_t             phase,
    output logic [SECBITS-1:0] sec_in_phase,
    output logic               fault,
    output fault_t             fault_code,
    output logic [7:0]         ped_cycles
);
    localparam logic [SECBITS-1:0] S_GM  = SECBITS'(T_GREENMAIN);
    localparam logic [SECBITS-1:0] S_YM  = SECBITS'(T_YELLOWMAIN);
    localparam logic [SECBITS-1:0] S_GS  = SECBITS'(T_GREENSEC);
    localparam logic [SECBITS-1:0] S_YS  = SECBITS'(T_YELLOWSEC);
    localparam logic [SECBITS-1:0] S_GP  = SECBITS'(T_GREENPEAT);
    localparam logic [SECBITS-1:0] S_RD  = SECBITS'(T_RED);
    localparam logic [SECBITS-1:0] S_RS  = SECBITS'(T_RESET);
    localparam logic [SECBITS-1:0] S_TOL = SECBITS'(TOL);

    phase_t             ph_d, phase_q;
    fault_t             viol, fault_q;
    logic               led_q, first_ar, fault_f;
    logic               change, trans_chk, tick;
    logic [SECBITS-1:0] secs, e_old, e_lo;

    assign ph_d      = decode_phase(lights.main_lights, lights.sec_lights, lights.peat_lights);
    assign change    = (ph_d != phase_q);
    assign trans_chk = change && (phase_q != PH_ILL) && (ph_d != PH_ILL);

    tl_sec_timer #(.FPGAFREQ(FPGAFREQ), .SECBITS(SECBITS)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (change),
        .tick  (tick),
        .secs  (secs)
    );

    always_comb begin
        e_old = '0;
        case (phase_q)
            PH_AR:   e_old = first_ar ? S_RS : S_RD;
            PH_MG:   e_old = S_GM;
            PH_MY:   e_old = S_YM;
            PH_SG:   e_old = S_GS;
            PH_SY:   e_old = S_YS;
            PH_PG:   e_old = S_GP;
            default: e_old = '0;
        endcase
        e_lo = (e_old > S_TOL) ? (e_old - S_TOL) : '0;
    end

    // Ordered lowest code first so the lowest simultaneous violation wins.
    // LONG is caught on the edge where secs would step to E+TOL+1.
    always_comb begin
        viol = F_NONE;
        if (ph_d == PH_ILL)
            viol = F_ILL_COMBO;
        else if (trans_chk && !legal_trans(phase_q, ph_d))
            viol = F_ILL_TRANS;
        else if (trans_chk && (secs < e_lo))
            viol = F_SHORT;
        else if (!change && (phase_q != PH_ILL) && tick && (secs == e_old + S_TOL))
            viol = F_LONG;
        else if (change && phase_q == PH_SY && ph_d == PH_PG && !led_q)
            viol = F_PED_SPURIOUS;
        else if (change && phase_q == PH_SY && ph_d == PH_MG && led_q)
            viol = F_PED_MISSED;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q  <= PH_AR;
            led_q    <= 1'b0;
            first_ar <= 1'b1;
            fault_f  <= 1'b0;
            fault_q  <= F_NONE;
        end else begin
            phase_q <= ph_d;
            led_q   <= lights.led_peatonal;
            if (change && phase_q == PH_AR) first_ar <= 1'b0;
            if (!fault_f && viol != F_NONE) begin
                fault_f <= 1'b1;
                fault_q <= viol;
            end
        end
    end

`ifdef TL_MON_PEDCNT_EN
    logic [7:0] ped_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ped_q <= '0;
        else if (change && ph_d == PH_PG && ped_q != 8'hFF)
            ped_q <= ped_q + 8'd1;
    end
    assign ped_cycles = ped_q;
`else
    assign ped_cycles = 8'd0;
`endif

    assign phase        = phase_q;
    assign sec_in_phase = secs;
    assign fault        = fault_f;
    assign fault_code   = fault_q;
endmodule
